inst_fetcher: RTL and testbench

- Instruction fetch stage that sits directly upstream of the instruction cache.
- Owns the PC and drives the lookup address into the cache.
- On a hit, passes the instruction into a one-entry registered output slot that feeds the decoder / instruction queue.
- On a miss, requests the whole block from the memory controller, writes it into the cache, then replays the fetch; redirects from the back end flush and restart fetch.

---
 rtl/inst_fetcher.sv | 130 +++++++++++++
 tb/tb_inst_fetcher.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, looks up the instruction cache, refills a block from
// memory on a miss, and presents one fetched instruction at a time through a registered slot.
module inst_fetcher #(
    parameter int unsigned BLOCK_BIT  = 128,
    parameter int unsigned OFFSET_BIT = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic [31:0]          icache_addr,
    input  logic                 icache_hit,
    input  logic [31:0]          icache_inst,
    output logic                 icache_we,
    output logic [BLOCK_BIT-1:0] icache_block,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_done,
    input  logic [BLOCK_BIT-1:0] mem_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT_MEM,
        FILL
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_pc;
    logic [31:0]          r_miss_addr;
    logic [BLOCK_BIT-1:0] r_block;
    logic                 r_out_valid;
    logic [31:0]          r_out_inst;
    logic [31:0]          r_out_pc;
    logic                 w_acc;
    logic                 w_take;
    logic                 w_miss;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= FETCH;
        end else if (rdy_in) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_acc        = !r_out_valid || out_ready;
        w_take       = 1'b0;
        w_miss       = 1'b0;
        icache_addr  = r_miss_addr;
        icache_we    = 1'b0;
        icache_block = r_block;
        mem_req      = 1'b0;
        mem_addr     = {r_miss_addr[31:OFFSET_BIT], {OFFSET_BIT{1'b0}}};
        case (r_state)
            FETCH: begin
                icache_addr = r_pc;
                w_take      = icache_hit && w_acc;
                // A redirect overrides a miss: the stale PC is never requested.
                w_miss      = !icache_hit && !redirect;
                if (w_miss) begin
                    w_next = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                mem_req = 1'b1;
                if (mem_done) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                icache_we = rdy_in;
                w_next    = FETCH;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc        <= RESET_PC;
            r_miss_addr <= '0;
            r_block     <= '0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
        end else if (rdy_in) begin
            // Redirect always wins for the PC, even while a miss is still being serviced.
            if (redirect) begin
                r_pc <= redirect_pc & ~32'h3;
            end else if (w_take) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_miss) begin
                r_miss_addr <= r_pc;
            end

            if (r_state == WAIT_MEM && mem_done) begin
                r_block <= mem_block;
            end

            if (redirect) begin
                r_out_valid <= 1'b0;
            end else if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= icache_inst;
                r_out_pc    <= r_pc;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_pc    = r_out_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: behavioural cache and memory models, a handshake scoreboard,
// and one task per scenario with inline checks.
module tb_inst_fetcher;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic [31:0]   icache_addr;
    logic          icache_hit;
    logic [31:0]   icache_inst;
    logic          icache_we;
    logic [127:0]  icache_block;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_done;
    logic [127:0]  mem_block;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic          redirect;
    logic [31:0]   redirect_pc;

    int            n_vec = 0;
    int            n_err = 0;
    int            mem_lat = 3;
    int            inv_cnt = 0;
    logic [63:0]   exp_q[$];

    logic [127:0]  c_data  [64];
    logic [21:0]   c_tag   [64];
    logic          c_valid [64];
    int            c_idx;

    inst_fetcher #(.BLOCK_BIT(128), .OFFSET_BIT(4), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_addr(icache_addr), .icache_hit(icache_hit), .icache_inst(icache_inst),
        .icache_we(icache_we), .icache_block(icache_block),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_block(mem_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return 32'hC000_0000 ^ a;
    endfunction

    function automatic logic [127:0] block_of(input logic [31:0] a);
        logic [127:0] b;
        logic [1:0]   w;
        for (int i = 0; i < 4; i++) begin
            w = 2'(i);
            b[i*32 +: 32] = mem_word({a[31:4], w, 2'b00});
        end
        return b;
    endfunction

    always_comb begin
        c_idx       = int'(icache_addr[9:4]);
        icache_hit  = c_valid[c_idx] && (c_tag[c_idx] == icache_addr[31:10]);
        icache_inst = c_data[c_idx][int'(icache_addr[3:2])*32 +: 32];
    end

    // Memory controller and cache storage: sample just before the edge, act just after it.
    initial begin
        int          cnt;
        int          inv_seen;
        logic        s_rdy, s_rst, s_req, s_done, s_we;
        logic [31:0] s_addr, s_iaddr;
        logic [127:0] s_blk;
        cnt = 0;
        inv_seen = 0;
        mem_done = 1'b0;
        mem_block = '0;
        for (int i = 0; i < 64; i++) begin
            c_valid[i] = 1'b0; c_tag[i] = '0; c_data[i] = '0;
        end
        forever begin
            @(negedge clk_in); #4;
            s_rdy = rdy_in; s_rst = rst_in; s_req = mem_req; s_done = mem_done;
            s_addr = mem_addr; s_we = icache_we; s_iaddr = icache_addr; s_blk = icache_block;
            @(posedge clk_in); #1;
            if (inv_seen != inv_cnt) begin
                for (int i = 0; i < 64; i++) c_valid[i] = 1'b0;
                inv_seen = inv_cnt;
            end
            if (s_we) begin
                c_valid[int'(s_iaddr[9:4])] = 1'b1;
                c_tag[int'(s_iaddr[9:4])]   = s_iaddr[31:10];
                c_data[int'(s_iaddr[9:4])]  = s_blk;
            end
            if (s_done && s_rdy) begin
                mem_done = 1'b0;
            end else if (s_req && s_rdy && !s_rst && !s_done) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_done = 1'b1;
                    mem_block = block_of(s_addr);
                    cnt = 0;
                end
            end
            if (!s_req) cnt = 0;
        end
    end

    // Scoreboard: every completed handshake pops the next expected {pc, inst}.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_in); #4;
            if (out_valid === 1'b1 && out_ready && rdy_in && !rst_in) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL handshake: got pc %h inst %h, expected no instruction", out_pc, out_inst);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_pc, out_inst} !== e) begin
                        n_err++;
                        $display("FAIL handshake: got pc %h inst %h, want pc %h inst %h",
                                 out_pc, out_inst, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic do_flush(input logic [31:0] p);
        logic [31:0] a;
        a = p & ~32'h3;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({a, mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic do_redirect(input logic [31:0] p);
        redirect = 1'b1;
        redirect_pc = p;
        tick();
        redirect = 1'b0;
        do_flush(p);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (out_valid !== 1'b1 && k < budget) begin tick(); k++; end
        if (out_valid !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got out_valid %b after %0d cycles, want 1", name, out_valid, k);
        end
    endtask

    task automatic wait_we(input int budget, input string name);
        int k = 0;
        while (icache_we !== 1'b1 && k < budget) begin tick(); k++; end
        if (icache_we !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got icache_we %b after %0d cycles, want 1", name, icache_we, k);
        end
    endtask

    task automatic wait_req(input logic [31:0] a, input int budget, input string name);
        int k = 0;
        while (!(mem_req === 1'b1 && mem_addr === a) && k < budget) begin tick(); k++; end
        if (!(mem_req === 1'b1 && mem_addr === a)) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got mem_req %b addr %h, want 1 addr %h", name, mem_req, mem_addr, a);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (3) tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", out_inst); end
        n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_vec++; if (icache_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", icache_we); end
        n_vec++; if (icache_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", icache_addr); end
    endtask

    task automatic test_cold_start();
        mem_lat = 3;
        do_flush(32'h0);
        rst_in = 1'b0;
        tick();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL cold_req: got req %b addr %h want 1 addr 0", mem_req, mem_addr); end
        wait_we(20, "cold_fill");
        n_vec++; if (icache_block !== block_of(32'h0) || icache_addr !== 32'h0) begin
            n_err++; $display("FAIL cold_block: got addr %h block %h want addr 0 block %h",
                              icache_addr, icache_block, block_of(32'h0)); end
        tick();
        n_vec++; if (icache_we !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL cold_we_pulse: got we %b valid %b want 0 0", icache_we, out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'(i*4) || out_inst !== 32'(17*(i+1))) begin
                n_err++; $display("FAIL cold_stream: got valid %b pc %h inst %h want 1 pc %h inst %h",
                                  out_valid, out_pc, out_inst, 32'(i*4), 32'(17*(i+1))); end
        end
        tick();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            n_err++; $display("FAIL cold_next_miss: got req %b addr %h want 1 addr 10", mem_req, mem_addr); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        do_redirect(32'h0);
        wait_valid(40, "bp_first");
        n_vec++; if (out_pc !== 32'h0 || out_inst !== 32'h11) begin
            n_err++; $display("FAIL bp_first: got pc %h inst %h want 0 11", out_pc, out_inst); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || icache_addr !== 32'h4) begin
                n_err++; $display("FAIL bp_hold: got valid %b pc %h addr %h want 1 0 4", out_valid, out_pc, icache_addr); end
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'(i*4)) begin
                n_err++; $display("FAIL bp_resume: got valid %b pc %h want 1 %h", out_valid, out_pc, 32'(i*4)); end
        end
        repeat (25) tick();
    endtask

    task automatic test_redirect_stream();
        int k = 0;
        do_redirect(32'h0);
        while (!(out_valid === 1'b1 && out_pc === 32'h8) && k < 40) begin tick(); k++; end
        if (!(out_valid === 1'b1 && out_pc === 32'h8)) begin
            n_vec++; n_err++; $display("FAIL rs_sync_timeout: got pc %h want 8", out_pc); end
        do_redirect(32'h1003);
        n_vec++; if (out_valid !== 1'b0 || icache_addr !== 32'h1000) begin
            n_err++; $display("FAIL rs_flush: got valid %b addr %h want 0 1000", out_valid, icache_addr); end
        wait_valid(40, "rs_new");
        n_vec++; if (out_pc !== 32'h1000 || out_inst !== mem_word(32'h1000)) begin
            n_err++; $display("FAIL rs_new: got pc %h inst %h want 1000 %h", out_pc, out_inst, mem_word(32'h1000)); end
        repeat (8) tick();
    endtask

    task automatic test_redirect_wait_mem();
        mem_lat = 8;
        inv_cnt++;
        do_redirect(32'h20);
        wait_req(32'h20, 40, "rw_req");
        do_redirect(32'h40);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || icache_addr !== 32'h20 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_hold: got req %b addr %h iaddr %h valid %b want 1 20 20 0",
                              mem_req, mem_addr, icache_addr, out_valid); end
        tick();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            n_err++; $display("FAIL rw_hold2: got req %b addr %h want 1 20", mem_req, mem_addr); end
        wait_we(30, "rw_fill");
        n_vec++; if (icache_addr !== 32'h20 || icache_block !== block_of(32'h20)) begin
            n_err++; $display("FAIL rw_fill: got addr %h block %h want 20 %h", icache_addr, icache_block, block_of(32'h20)); end
        tick();
        n_vec++; if (icache_we !== 1'b0 || icache_addr !== 32'h40) begin
            n_err++; $display("FAIL rw_resume: got we %b addr %h want 0 40", icache_we, icache_addr); end
        wait_valid(40, "rw_new");
        n_vec++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL rw_new: got pc %h want 40", out_pc); end
    endtask

    task automatic test_rdy_freeze();
        mem_lat = 4;
        inv_cnt++;
        do_redirect(32'h80);
        wait_req(32'h80, 40, "rf_req");
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || icache_we !== 1'b0 ||
                         icache_addr !== 32'h80 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL rf_wait_frozen: got req %b addr %h we %b iaddr %h valid %b want 1 80 0 80 0",
                                  mem_req, mem_addr, icache_we, icache_addr, out_valid); end
        end
        rdy_in = 1'b1;
        wait_valid(40, "rf_first");
        n_vec++; if (out_pc !== 32'h80) begin n_err++; $display("FAIL rf_first: got pc %h want 80", out_pc); end
        tick();
        tick();
        n_vec++; if (out_pc !== 32'h88) begin n_err++; $display("FAIL rf_stream: got pc %h want 88", out_pc); end
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h88 || out_inst !== mem_word(32'h88) ||
                         icache_addr !== 32'h8C || icache_we !== 1'b0 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL rf_stream_frozen: got valid %b pc %h inst %h iaddr %h we %b req %b want 1 88 %h 8c 0 0",
                                  out_valid, out_pc, out_inst, icache_addr, icache_we, mem_req, mem_word(32'h88)); end
        end
        rdy_in = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h8C) begin
            n_err++; $display("FAIL rf_after: got valid %b pc %h want 1 8c", out_valid, out_pc); end
    endtask

    task automatic test_reset_fill();
        mem_lat = 3;
        inv_cnt++;
        do_redirect(32'hC0);
        wait_we(40, "rst_fill");
        rst_in = 1'b1;
        tick();
        n_vec++; if (icache_we !== 1'b0 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_fill_ctl: got we %b req %b valid %b want 0 0 0", icache_we, mem_req, out_valid); end
        n_vec++; if (icache_addr !== 32'h0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_err++; $display("FAIL rst_fill_regs: got iaddr %h pc %h inst %h want 0 0 0", icache_addr, out_pc, out_inst); end
        rst_in = 1'b0;
        do_flush(32'h0);
        wait_valid(40, "rst_restart");
        n_vec++; if (out_pc !== 32'h0 || out_inst !== 32'h11) begin
            n_err++; $display("FAIL rst_restart: got pc %h inst %h want 0 11", out_pc, out_inst); end
    endtask

    task automatic test_wrap();
        do_redirect(32'hFFFF_FFF8);
        wait_valid(40, "wrap_first");
        n_vec++; if (out_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_first: got pc %h want fffffff8", out_pc); end
        tick();
        n_vec++; if (out_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_last: got pc %h want fffffffc", out_pc); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h11) begin
            n_err++; $display("FAIL wrap_zero: got valid %b pc %h inst %h want 1 0 11", out_valid, out_pc, out_inst); end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_back_pressure();
        test_redirect_stream();
        test_redirect_wait_mem();
        test_rdy_freeze();
        test_reset_fill();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
